// File: rtl/md_pad_ports.sv
// Mega Drive controller-port block: CPU data/ctrl registers per port, a TH
// sequencer with float and timeout handling, and pad read-back muxing.
module md_pad_ports #(
    parameter int unsigned NPORTS      = 2,
    parameter int unsigned TMO_TICKS   = 11600,
    parameter int unsigned FLOAT_TICKS = 210
) (
    input  logic                  CLK,
    input  logic                  RESET_N,
    input  logic                  CE,
    input  logic                  SEL,
    input  logic [3:0]            A,
    input  logic                  RNW,
    input  logic [7:0]            DI,
    output logic [7:0]            DO,
    output logic                  DTACK_N,
    input  logic [2*NPORTS-1:0]   PAD_MODE,
    input  logic [12*NPORTS-1:0]  BTN_N,
    input  logic [7:0]            VERSION
);

    localparam int unsigned NREGS = 16;
    localparam int unsigned TMO_W = $clog2(TMO_TICKS + 1);

    // Button bit positions inside a port's 12-bit BTN_N slice.
    localparam int unsigned B_UP = 0, B_DN = 1, B_LT = 2, B_RT = 3;
    localparam int unsigned B_A = 4, B_B = 5, B_C = 6, B_ST = 7;
    localparam int unsigned B_MD = 8, B_X = 9, B_Y = 10, B_Z = 11;

    logic [7:0]       regs_q  [NREGS];
    logic [7:0]       regs_d  [NREGS];
    logic [7:0]       do_q, do_d;
    logic             dtack_n_q, dtack_n_d;
    logic             th_q    [NPORTS];
    logic             th_d    [NPORTS];
    logic [2:0]       phase_q [NPORTS];
    logic [2:0]       phase_d [NPORTS];
    logic [TMO_W-1:0] tmo_q   [NPORTS];
    logic [TMO_W-1:0] tmo_d   [NPORTS];
    logic [7:0]       flt_q   [NPORTS];
    logic [7:0]       flt_d   [NPORTS];
    logic [7:0]       pad_c   [NPORTS];
    logic [7:0]       rd_data_c;

    assign DO      = do_q;
    assign DTACK_N = dtack_n_q;

    // Pad value seen by the CPU for one port, from its mode, buttons, th and phase.
    function automatic logic [7:0] pad_value(input logic [1:0] mode, input logic [11:0] b,
                                             input logic th, input logic [2:0] ph);
        logic [5:0] lo;
        logic [7:0] res;
        lo = {b[B_C], b[B_B], b[B_RT], b[B_LT], b[B_DN], b[B_UP]};
        if (mode[1]) begin
            case (ph)
                3'd1, 3'd3: lo = {b[B_ST], b[B_A], 2'b00, b[B_DN], b[B_UP]};
                3'd5:       lo = {b[B_ST], b[B_A], 4'b0000};
                3'd6:       lo = {b[B_C], b[B_B], b[B_MD], b[B_X], b[B_Y], b[B_Z]};
                3'd7:       lo = {b[B_ST], b[B_A], 4'b1111};
                default:    ;
            endcase
        end else if (!th) begin
            lo = {b[B_ST], b[B_A], 2'b00, b[B_DN], b[B_UP]};
        end
        if (mode == 2'd0) res = 8'h7F;
        else              res = {1'b0, th, lo};
        return res;
    endfunction

    // Per-port pad values, combinational from registered th/phase.
    always_comb begin
        for (int p = 0; p < NPORTS; p++) begin
            pad_c[p] = pad_value(PAD_MODE[2*p +: 2], BTN_N[12*p +: 12], th_q[p], phase_q[p]);
        end
    end

    // Read-data mux for the addressed register.
    always_comb begin
        rd_data_c = regs_q[A];
        if (A == 4'd0) begin
            rd_data_c = VERSION;
        end else if (A <= 4'd6) begin
            rd_data_c = 8'hFF;
            for (int p = 0; p < NPORTS; p++) begin
                if (A == 4'(1 + p)) begin
                    rd_data_c = (regs_q[4'(4 + p)] & regs_q[4'(1 + p)])
                              | (~regs_q[4'(4 + p)] & pad_c[p]);
                end
                if (A == 4'(4 + p)) begin
                    rd_data_c = regs_q[4'(4 + p)];
                end
            end
        end
    end

    // Bus handshake: one access per SEL assertion, acknowledged until SEL drops.
    always_comb begin
        regs_d    = regs_q;
        do_d      = do_q;
        dtack_n_d = dtack_n_q;
        if (CE) begin
            if (!SEL) begin
                dtack_n_d = 1'b1;
            end else if (dtack_n_q) begin
                dtack_n_d = 1'b0;
                if (RNW) do_d = rd_data_c;
                else     regs_d[A] = DI;
            end
        end
    end

    // TH source, float timer, phase counter and idle timeout per port.
    always_comb begin
        logic [7:0] ctl;
        logic [7:0] dat;
        logic       timed_out;
        ctl       = 8'h00;
        dat       = 8'h00;
        timed_out = 1'b0;
        for (int p = 0; p < NPORTS; p++) begin
            th_d[p]    = th_q[p];
            flt_d[p]   = flt_q[p];
            phase_d[p] = phase_q[p];
            tmo_d[p]   = tmo_q[p];
            if (CE) begin
                ctl = regs_q[4'(4 + p)];
                dat = regs_q[4'(1 + p)];
                if (ctl[6]) begin
                    th_d[p]  = dat[6];
                    flt_d[p] = 8'h00;
                end else begin
                    if (flt_q[p] != 8'hFF)           flt_d[p] = flt_q[p] + 8'd1;
                    if (flt_q[p] == 8'(FLOAT_TICKS)) th_d[p]  = 1'b1;
                end
                timed_out = (tmo_q[p] >= TMO_W'(TMO_TICKS));
                if (th_d[p] != th_q[p]) begin
                    // An edge coinciding with a timeout counts from phase 0.
                    phase_d[p] = (timed_out ? 3'd0 : phase_q[p]) + 3'd1;
                    tmo_d[p]   = '0;
                end else begin
                    if (tmo_q[p] != {TMO_W{1'b1}}) tmo_d[p] = tmo_q[p] + TMO_W'(1);
                    if (timed_out)                phase_d[p] = 3'd0;
                end
            end
        end
    end

    // State registers.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= (i >= 1 && i <= NPORTS) ? 8'h7F : 8'h00;
            end
            do_q      <= 8'hFF;
            dtack_n_q <= 1'b1;
            for (int p = 0; p < NPORTS; p++) begin
                th_q[p]    <= 1'b1;
                phase_q[p] <= 3'd0;
                tmo_q[p]   <= '0;
                flt_q[p]   <= 8'h00;
            end
        end else begin
            regs_q    <= regs_d;
            do_q      <= do_d;
            dtack_n_q <= dtack_n_d;
            th_q      <= th_d;
            phase_q   <= phase_d;
            tmo_q     <= tmo_d;
            flt_q     <= flt_d;
        end
    end

endmodule

// File: tb/tb_md_pad_ports.sv
// Bench for md_pad_ports: directed port scenarios plus randomized bus traffic,
// checked every cycle against a behavioural model of the port rules.
module tb_md_pad_ports;

    localparam int NP    = 2;
    localparam int TMO   = 60;
    localparam int FLOAT = 25;

    logic           CLK = 1'b0;
    logic           RESET_N, CE, SEL, RNW;
    logic [3:0]     A;
    logic [7:0]     DI, DO, VERSION;
    logic           DTACK_N;
    logic [2*NP-1:0]  PAD_MODE;
    logic [12*NP-1:0] BTN_N;

    md_pad_ports #(.NPORTS(NP), .TMO_TICKS(TMO), .FLOAT_TICKS(FLOAT)) dut (
        .CLK(CLK), .RESET_N(RESET_N), .CE(CE), .SEL(SEL), .A(A), .RNW(RNW),
        .DI(DI), .DO(DO), .DTACK_N(DTACK_N), .PAD_MODE(PAD_MODE), .BTN_N(BTN_N),
        .VERSION(VERSION)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;
    bit rand_ce = 1'b0;

    // Model state
    logic [7:0] m_regs [16];
    logic       m_th   [NP];
    int         m_phase[NP];
    int         m_tmo  [NP];
    int         m_flt  [NP];
    logic [7:0] m_do;
    logic       m_dt_n;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %02h, expected %02h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_regs[i] = (i >= 1 && i <= NP) ? 8'h7F : 8'h00;
        for (int p = 0; p < NP; p++) begin
            m_th[p] = 1'b1; m_phase[p] = 0; m_tmo[p] = 0; m_flt[p] = 0;
        end
        m_do   = 8'hFF;
        m_dt_n = 1'b1;
    endtask

    function automatic logic btn_level(input byte c, input logic [11:0] b);
        case (c)
            "U": return b[0];
            "D": return b[1];
            "L": return b[2];
            "R": return b[3];
            "A": return b[4];
            "B": return b[5];
            "C": return b[6];
            "S": return b[7];
            "M": return b[8];
            "X": return b[9];
            "Y": return b[10];
            "Z": return b[11];
            "1": return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Pad value from a textual row per phase/mode (leftmost char is bit 5).
    function automatic logic [7:0] model_pad(input int p);
        logic [1:0]  mode;
        logic [11:0] b;
        string       row;
        logic [7:0]  v;
        mode = PAD_MODE[2*p +: 2];
        b    = BTN_N[12*p +: 12];
        if (mode == 2'd0) return 8'h7F;
        if (mode == 2'd1) row = m_th[p] ? "CBRLDU" : "SA00DU";
        else begin
            case (m_phase[p])
                0, 2, 4: row = "CBRLDU";
                1, 3:    row = "SA00DU";
                5:       row = "SA0000";
                6:       row = "CBMXYZ";
                default: row = "SA1111";
            endcase
        end
        v = {1'b0, m_th[p], 6'b0};
        for (int i = 0; i < 6; i++) v[5-i] = btn_level(row[i], b);
        return v;
    endfunction

    function automatic logic [7:0] model_read(input int a);
        int p;
        if (a == 0) return VERSION;
        if (a >= 1 && a <= 3) begin
            p = a - 1;
            if (p >= NP) return 8'hFF;
            return (m_regs[4+p] & m_regs[1+p]) | (~m_regs[4+p] & model_pad(p));
        end
        if (a >= 4 && a <= 6) begin
            p = a - 4;
            if (p >= NP) return 8'hFF;
        end
        return m_regs[a];
    endfunction

    // One CE tick of the model, all decisions from pre-tick state.
    task automatic model_step();
        logic [7:0] rd;
        logic       wr;
        logic       nth;
        rd = model_read(int'(A));
        wr = 1'b0;
        if (!SEL) m_dt_n = 1'b1;
        else if (m_dt_n) begin
            m_dt_n = 1'b0;
            if (RNW) m_do = rd;
            else     wr = 1'b1;
        end
        for (int p = 0; p < NP; p++) begin
            nth = m_th[p];
            if (m_regs[4+p][6]) begin
                nth = m_regs[1+p][6];
                m_flt[p] = 0;
            end else begin
                if (m_flt[p] == FLOAT) nth = 1'b1;
                m_flt[p] = (m_flt[p] < 255) ? m_flt[p] + 1 : 255;
            end
            if (nth != m_th[p]) begin
                m_phase[p] = (((m_tmo[p] >= TMO) ? 0 : m_phase[p]) + 1) % 8;
                m_tmo[p]   = 0;
            end else begin
                if (m_tmo[p] >= TMO) m_phase[p] = 0;
                m_tmo[p] = (m_tmo[p] < TMO) ? m_tmo[p] + 1 : TMO;
            end
            m_th[p] = nth;
        end
        if (wr) m_regs[A] = DI;
    endtask

    // Advance one clock, step the model, compare at the falling edge.
    task automatic tick();
        CE = rand_ce ? 1'($urandom_range(0, 3) != 0) : 1'b1;
        @(posedge CLK);
        if (RESET_N && CE) model_step();
        @(negedge CLK);
        check("do", DO, m_do);
        check("dtack_n", {7'b0, DTACK_N}, {7'b0, m_dt_n});
    endtask

    task automatic access(input logic rnw, input logic [3:0] a, input logic [7:0] d,
                          output logic [7:0] q);
        int n;
        SEL = 1'b1; RNW = rnw; A = a; DI = d;
        n = 0;
        do begin tick(); n++; end while (DTACK_N !== 1'b0 && n < 64);
        check("ack_seen", {7'b0, DTACK_N}, 8'h00);
        q = DO;
        SEL = 1'b0;
        n = 0;
        do begin tick(); n++; end while (DTACK_N !== 1'b1 && n < 64);
        check("ack_release", {7'b0, DTACK_N}, 8'h01);
    endtask

    task automatic do_reset();
        RESET_N = 1'b0;
        SEL = 1'b0;
        model_reset();
        repeat (2) tick();
        RESET_N = 1'b1;
    endtask

    logic [7:0] q;
    logic [7:0] exp6 [8];
    logic [7:0] dat_seq [8];

    initial begin
        RESET_N = 1'b0; CE = 1'b0; SEL = 1'b0; RNW = 1'b1; A = 4'd0; DI = 8'h00;
        VERSION = 8'hA5; PAD_MODE = '0; BTN_N = '1;
        dat_seq = '{8'h00, 8'h40, 8'h00, 8'h40, 8'h00, 8'h40, 8'h00, 8'h40};
        exp6    = '{8'h23, 8'h7F, 8'h23, 8'h7F, 8'h20, 8'h7B, 8'h2F, 8'h7F};
        model_reset();
        @(negedge CLK);

        // Reset state and simple reads
        PAD_MODE = {2'd0, 2'd2};
        do_reset();
        check("reset_do", DO, 8'hFF);
        check("reset_dtack", {7'b0, DTACK_N}, 8'h01);
        access(1'b1, 4'd1, 8'h00, q); check("idle_read", q, 8'h7F);
        access(1'b1, 4'd0, 8'h00, q); check("version", q, 8'hA5);
        access(1'b1, 4'd3, 8'h00, q); check("absent_data", q, 8'hFF);
        access(1'b1, 4'd6, 8'h00, q); check("absent_ctrl", q, 8'hFF);

        // 6-button sequence, A and X pressed on port 0
        BTN_N[4] = 1'b0; BTN_N[9] = 1'b0;
        access(1'b0, 4'd4, 8'h40, q);
        for (int i = 0; i < 8; i++) begin
            access(1'b0, 4'd1, dat_seq[i], q);
            access(1'b1, 4'd1, 8'h00, q);
            check($sformatf("six_btn_%0d", i), q, exp6[i]);
        end

        // 3-button mode: phases 6/7 look like phases 0/1
        PAD_MODE = {2'd0, 2'd1};
        for (int i = 0; i < 8; i++) begin
            access(1'b0, 4'd1, dat_seq[i], q);
            access(1'b1, 4'd1, 8'h00, q);
            check($sformatf("three_btn_%0d", i), q, (i % 2 == 0) ? 8'h23 : 8'h7F);
        end

        // Phase timeout
        BTN_N = '1;
        PAD_MODE = {2'd0, 2'd2};
        do_reset();
        access(1'b0, 4'd4, 8'h40, q);
        access(1'b0, 4'd1, 8'h00, q);
        access(1'b0, 4'd1, 8'h40, q);
        access(1'b0, 4'd1, 8'h00, q);
        repeat (TMO + 3) tick();
        access(1'b1, 4'd1, 8'h00, q); check("timeout_phase0", q, 8'h3F);

        // TH floats high after FLOAT ticks as an input
        access(1'b0, 4'd4, 8'h00, q);
        access(1'b1, 4'd1, 8'h00, q); check("float_early", {7'b0, q[6]}, 8'h00);
        repeat (FLOAT + 5) tick();
        access(1'b1, 4'd1, 8'h00, q); check("float_late", {7'b0, q[6]}, 8'h01);

        // One write per SEL assertion even with DI changing
        SEL = 1'b1; RNW = 1'b0; A = 4'd8; DI = 8'h5A;
        tick();
        DI = 8'hA5;
        repeat (4) tick();
        SEL = 1'b0;
        tick();
        access(1'b1, 4'd8, 8'h00, q); check("single_write", q, 8'h5A);

        // Reset in the middle of an access
        SEL = 1'b1; RNW = 1'b1; A = 4'd1;
        begin
            int n;
            n = 0;
            do begin tick(); n++; end while (DTACK_N !== 1'b0 && n < 16);
        end
        check("pre_rst_ack", {7'b0, DTACK_N}, 8'h00);
        #2 RESET_N = 1'b0;
        model_reset();
        #1;
        check("rst_async_dtack", {7'b0, DTACK_N}, 8'h01);
        check("rst_async_do", DO, 8'hFF);
        SEL = 1'b0;
        @(negedge CLK);
        repeat (2) tick();
        RESET_N = 1'b1;

        // Randomized traffic with random CE, modes, buttons and idle gaps
        rand_ce = 1'b1;
        for (int t = 0; t < 400; t++) begin
            logic [3:0] a;
            logic [7:0] d;
            if ($urandom_range(0, 9) == 0) PAD_MODE = 4'($urandom);
            if ($urandom_range(0, 3) == 0) BTN_N = 24'($urandom);
            case ($urandom_range(0, 5))
                0, 1:    a = 4'($urandom_range(1, 2));
                2:       a = 4'($urandom_range(4, 5));
                default: a = 4'($urandom);
            endcase
            d = 8'($urandom);
            if ($urandom_range(0, 1) == 0) d[6] = ~d[6];
            access(1'($urandom_range(0, 1)), a, d, q);
            if ($urandom_range(0, 9) == 0) repeat ($urandom_range(0, 90)) tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
